// File: rtl/rv32i_fetch_ctrl.sv
// RV32I instruction fetch controller: IDLE/REQ/HOLD sequencer feeding rv32i_decoder.
// Optional one-entry skid buffer for fetching during downstream stalls: define FETCH_SKID_EN.
module rv32i_fetch_ctrl #(
    parameter logic [31:0] PC_RESET = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    output logic [31:0] o_iaddr,
    output logic        o_ireq,
    input  logic        i_ack,
    input  logic [31:0] i_inst,
    output logic [31:0] o_inst,
    output logic [31:0] o_pc,
    output logic        o_valid,
    input  logic        i_stall,
    input  logic        i_change_pc,
    input  logic [31:0] i_new_pc,
    output logic [1:0]  dbg_state
);

    // Handshakes: a memory word is taken when o_ireq && i_ack in the same cycle;
    // an output instruction is taken by the decoder when o_valid && !i_stall.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    localparam logic [31:0] PC_INIT = PC_RESET & 32'hFFFF_FFFC;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [31:0] redirect_pc;
    logic        ack_taken;
    logic        consumed;
    logic        can_load;

`ifdef FETCH_SKID_EN
    logic        skid_valid;
    logic [31:0] skid_inst;
    logic [31:0] skid_pc;
`endif

    assign pc_next     = pc + 32'd4;
    assign redirect_pc = i_new_pc & 32'hFFFF_FFFC;
    assign ack_taken   = o_ireq & i_ack;
    assign consumed    = o_valid & ~i_stall;
    // The output slot may be overwritten only if it is empty or being drained this cycle.
    assign can_load    = ~o_valid | ~i_stall;
    assign o_iaddr     = pc;
    assign dbg_state   = state;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state   <= ST_IDLE;
            pc      <= PC_INIT;
            o_ireq  <= 1'b0;
            o_valid <= 1'b0;
            o_inst  <= NOP_INST;
            o_pc    <= PC_INIT;
`ifdef FETCH_SKID_EN
            skid_valid <= 1'b0;
            skid_inst  <= NOP_INST;
            skid_pc    <= PC_INIT;
`endif
        end else if (i_change_pc) begin
            // Redirect wins over everything, including a same-cycle acknowledge.
            state   <= ST_IDLE;
            pc      <= redirect_pc;
            o_ireq  <= 1'b0;
            o_valid <= 1'b0;
            o_inst  <= NOP_INST;
`ifdef FETCH_SKID_EN
            skid_valid <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    state  <= ST_REQ;
                    o_ireq <= 1'b1;
                end

                ST_REQ: begin
                    if (ack_taken) begin
                        if (can_load) begin
                            o_inst  <= i_inst;
                            o_pc    <= pc;
                            o_valid <= 1'b1;
                            pc      <= pc_next;
                            if (i_stall) begin
                                state <= ST_HOLD;
`ifdef FETCH_SKID_EN
                                o_ireq <= 1'b1;
`else
                                o_ireq <= 1'b0;
`endif
                            end
                        end else begin
                            // Output slot still owned by a stalled instruction.
`ifdef FETCH_SKID_EN
                            skid_valid <= 1'b1;
                            skid_inst  <= i_inst;
                            skid_pc    <= pc;
                            pc         <= pc_next;
`endif
                            state  <= ST_HOLD;
                            o_ireq <= 1'b0;
                        end
                    end else if (consumed) begin
                        o_valid <= 1'b0;
                        o_inst  <= NOP_INST;
                    end
                end

                ST_HOLD: begin
                    if (!i_stall) begin
                        state  <= ST_REQ;
                        o_ireq <= 1'b1;
`ifdef FETCH_SKID_EN
                        if (skid_valid) begin
                            o_inst     <= skid_inst;
                            o_pc       <= skid_pc;
                            o_valid    <= 1'b1;
                            skid_valid <= 1'b0;
                        end else if (ack_taken) begin
                            o_inst  <= i_inst;
                            o_pc    <= pc;
                            o_valid <= 1'b1;
                            pc      <= pc_next;
                        end else begin
                            o_valid <= 1'b0;
                            o_inst  <= NOP_INST;
                        end
`else
                        o_valid <= 1'b0;
                        o_inst  <= NOP_INST;
`endif
                    end else begin
`ifdef FETCH_SKID_EN
                        if (ack_taken) begin
                            skid_valid <= 1'b1;
                            skid_inst  <= i_inst;
                            skid_pc    <= pc;
                            pc         <= pc_next;
                            o_ireq     <= 1'b0;
                        end
`endif
                    end
                end

                default: begin
                    state  <= ST_IDLE;
                    o_ireq <= 1'b0;
                end
            endcase
        end
    end

endmodule
